// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words from an s_en-qualified bit stream.
// Latency: the word is visible on p_out/p_valid the cycle after its last bit is sampled.
// Backpressure: one-word output buffer; a completed word arriving while full and not accepted is dropped and sets sticky overrun.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             s_in,
    input  logic             s_en,
    input  logic             sync,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Bit assembly state
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Output buffer state
    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             ovr_q, ovr_d;

    // Derived per-edge values
    logic [WIDTH-1:0] word_shifted;
    logic [CW-1:0]    cnt_eff;
    logic             word_done;

    // Shift register contents after sampling s_in; also the completed word when this is the last bit.
    // LSB-first mirrors the transmit shifter so a PISO stream reassembles to its original parallel word.
    always_comb begin
        word_shifted = sh_q;
        if (LSB_FIRST) begin
            word_shifted = {s_in, sh_q[WIDTH-1:1]};
        end else begin
            word_shifted = {sh_q[WIDTH-2:0], s_in};
        end
    end

    // A sync pulse forces this edge's bit to be bit 0 of a fresh word, so completion uses the realigned count.
    assign cnt_eff   = sync ? '0 : cnt_q;
    assign word_done = s_en && (cnt_eff == LAST);

    // Next-state for shift register and bit count; gaps in s_en simply hold both.
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (s_en) begin
            sh_d  = word_shifted;
            cnt_d = (cnt_eff == LAST) ? '0 : cnt_eff + CW'(1);
        end else if (sync) begin
            cnt_d = '0;
        end
    end

    // Output buffer next-state: load when empty, replace when consumed on the same edge, drop when blocked.
    always_comb begin
        state_d = state_q;
        pout_d  = pout_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_EMPTY: begin
                if (word_done) begin
                    state_d = ST_FULL;
                    pout_d  = word_shifted;
                end
            end
            ST_FULL: begin
                if (word_done) begin
                    if (p_ready) begin
                        pout_d = word_shifted;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (p_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State registers; clear wins over every other input.
    always_ff @(posedge clk) begin
        if (clear) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_EMPTY;
            pout_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pout_q  <= pout_d;
            ovr_q   <= ovr_d;
        end
    end

    assign p_out   = pout_q;
    assign p_valid = (state_q == ST_FULL);
    assign overrun = ovr_q;
    assign busy    = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    logic       clk;
    logic       clear;
    logic       s_in;
    logic       s_en;
    logic       sync;
    logic       p_ready;

    logic [3:0] p_out_l, p_out_m;
    logic       p_valid_l, p_valid_m;
    logic       overrun_l, overrun_m;
    logic       busy_l, busy_m;

    int n_cmp;
    int n_bad;

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clk     (clk),
        .clear   (clear),
        .s_in    (s_in),
        .s_en    (s_en),
        .sync    (sync),
        .p_out   (p_out_l),
        .p_valid (p_valid_l),
        .p_ready (p_ready),
        .overrun (overrun_l),
        .busy    (busy_l)
    );

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clk     (clk),
        .clear   (clear),
        .s_in    (s_in),
        .s_en    (s_en),
        .sync    (sync),
        .p_out   (p_out_m),
        .p_valid (p_valid_m),
        .p_ready (p_ready),
        .overrun (overrun_m),
        .busy    (busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       en;
        logic       din;
        logic       syn;
        logic       rdy;
        logic       chk_p;
        logic [3:0] p;
        logic       pv;
        logic       ov;
        logic       bz;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic clr, input logic en, input logic din, input logic syn,
                       input logic rdy, input logic chk_p, input logic [3:0] p,
                       input logic pv, input logic ov, input logic bz);
        vec_t v;
        v.clr = clr; v.en = en; v.din = din; v.syn = syn; v.rdy = rdy;
        v.chk_p = chk_p; v.p = p; v.pv = pv; v.ov = ov; v.bz = bz;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Apply one set of inputs across one rising edge, then let outputs settle.
    task automatic step(input logic clr, input logic en, input logic din, input logic syn, input logic rdy);
        clear   = clr;
        s_en    = en;
        s_in    = din;
        sync    = syn;
        p_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        clear   = 1'b1;
        s_in    = 1'b0;
        s_en    = 1'b0;
        sync    = 1'b0;
        p_ready = 1'b0;

        //    clr en din syn rdy chkp p     pv ov bz
        // Reset state
        add(1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0);
        // Back-to-back bits 1,0,1,1 LSB first -> D, valid exactly one cycle
        add(0, 1, 1, 0, 1, 1, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 1, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 1, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 1, 4'hD, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
        // Same stream with s_en gaps: bits on relative cycles 0,3,4,9
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 1, 4'hD, 1, 0, 0);
        // Full with no ready holds, ready drains
        add(0, 0, 0, 0, 0, 1, 4'hD, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
        // Overrun: 3 then 5 with ready low; 5 is dropped
        add(0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 4'h3, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1, 4'h3, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 4'h3, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 4'h3, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 4'h3, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0);
        // Simultaneous accept + completion: A held, 6 replaces it, no overrun
        add(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 4'hA, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 4'hA, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 4'hA, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 4'hA, 1, 0, 1);
        add(0, 1, 0, 0, 1, 1, 4'h6, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
        // Realign: 2 bits, sync with bit 1, then 1,0,0 -> 3
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 1, 4'h3, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);
        // sync without s_en discards the partial word
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 0, 1, 1, 1, 0, 4'h0, 0, 0, 0);
        // Clear mid-word (with s_en high) wins; next 4 bits 1,0,0,1 -> 9
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(1, 1, 1, 0, 1, 1, 4'h0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 1, 4'h9, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].clr, vq[i].en, vq[i].din, vq[i].syn, vq[i].rdy);
            if (vq[i].chk_p) check("p_out", i, 32'(p_out_l), 32'(vq[i].p));
            check("p_valid", i, 32'(p_valid_l), 32'(vq[i].pv));
            check("overrun", i, 32'(overrun_l), 32'(vq[i].ov));
            check("busy", i, 32'(busy_l), 32'(vq[i].bz));
        end

        // MSB-first ordering: 1,0,1,1 -> B on the MSB instance, D on the LSB instance
        step(1, 0, 0, 0, 1);
        check("msb_reset_p_out", 100, 32'(p_out_m), 32'h0);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        check("msb_mid_valid", 101, 32'(p_valid_m), 32'h0);
        check("msb_mid_busy", 101, 32'(busy_m), 32'h1);
        step(0, 1, 1, 0, 1);
        check("msb_p_out", 102, 32'(p_out_m), 32'hB);
        check("msb_p_valid", 102, 32'(p_valid_m), 32'h1);
        check("lsb_p_out_same_stream", 102, 32'(p_out_l), 32'hD);
        check("msb_busy_done", 102, 32'(busy_m), 32'h0);

        // MSB-first overrun keeps the first word (1,1,0,0 -> C) and drops 0,1,0,1
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("msb_word2", 103, 32'(p_out_m), 32'hC);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("msb_ovr_hold_p_out", 104, 32'(p_out_m), 32'hC);
        check("msb_overrun", 104, 32'(overrun_m), 32'h1);
        step(0, 0, 0, 0, 1);
        check("msb_drain_valid", 105, 32'(p_valid_m), 32'h0);
        check("msb_overrun_sticky", 105, 32'(overrun_m), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
